sysid_boot_checker: RTL and testbench

SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

---
 rtl/sysid_boot_checker_if.sv | 8 +
 rtl/sysid_boot_checker.sv | 113 +++++++++++
 tb/tb_sysid_boot_checker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sysid_boot_checker_if.sv
// sysid_boot_checker_if: sysid word-select/read bus between the checker and the sysid slave.
interface sysid_boot_checker_if;
    logic        sys_address;
    logic        sys_read;
    logic [31:0] sys_readdata;
    modport master (output sys_address, sys_read, input sys_readdata);
    modport slave (input sys_address, sys_read, output sys_readdata);
endinterface

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads the sysid ID/timestamp words after reset, compares them, retries on mismatch.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1400059473,
    parameter int          READ_LATENCY = 1,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    sysid_boot_checker_if.master         bus,
    output logic [31:0]                  id_value,
    output logic [31:0]                  ts_value,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   mismatch,
    output logic [1:0]                   retry_count
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ID   = 3'd1;
    localparam logic [2:0] RD_TS   = 3'd2;
    localparam logic [2:0] COMPARE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0] state;
    logic [3:0] cnt;
    logic       last;
    logic [1:0] mm_now;

    assign last   = cnt == 4'(READ_LATENCY - 1);
    assign mm_now = {ts_value != EXPECTED_TS, id_value != EXPECTED_ID};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            id_value        <= '0;
            ts_value        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            mismatch        <= '0;
            retry_count     <= '0;
            bus.sys_read    <= 1'b0;
            bus.sys_address <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state           <= RD_ID;
                    cnt             <= '0;
                    busy            <= 1'b1;
                    bus.sys_read    <= 1'b1;
                    bus.sys_address <= 1'b0;
                end
                RD_ID: begin
                    if (last) begin
                        id_value        <= bus.sys_readdata;
                        state           <= RD_TS;
                        cnt             <= '0;
                        bus.sys_address <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'(cnt != 4'hf);
                    end
                end
                RD_TS: begin
                    if (last) begin
                        ts_value     <= bus.sys_readdata;
                        state        <= COMPARE;
                        cnt          <= '0;
                        bus.sys_read <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'(cnt != 4'hf);
                    end
                end
                COMPARE: begin
                    mismatch <= mm_now;
                    cnt      <= '0;
                    if (mm_now != 2'b00 && retry_count < 2'(MAX_RETRIES)) begin
                        // address stays at 1 until the next read strobe starts
                        retry_count     <= retry_count + 2'd1;
                        state           <= RD_ID;
                        bus.sys_read    <= 1'b1;
                        bus.sys_address <= 1'b0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= mm_now == 2'b00;
                        fail  <= mm_now != 2'b00;
                    end
                end
                DONE: begin
                    if (start) begin
                        state           <= RD_ID;
                        cnt             <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        fail            <= 1'b0;
                        mismatch        <= '0;
                        retry_count     <= '0;
                        bus.sys_read    <= 1'b1;
                        bus.sys_address <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: directed checks of the sysid boot checker at READ_LATENCY 1 and 3.
module tb_sysid_boot_checker;
    localparam logic [31:0] GOOD_TS = 32'd1400059473;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    sysid_boot_checker_if bus1 ();
    sysid_boot_checker_if bus3 ();

    logic [31:0] id1, ts1, id3, ts3;
    logic        busy1, done1, pass1, fail1, busy3, done3, pass3, fail3;
    logic [1:0]  mm1, rc1, mm3, rc3;

    sysid_boot_checker u1 (
        .clock(clock), .reset_n(reset_n), .start(start), .bus(bus1.master),
        .id_value(id1), .ts_value(ts1), .busy(busy1), .done(done1), .pass(pass1),
        .fail(fail1), .mismatch(mm1), .retry_count(rc1)
    );

    sysid_boot_checker #(.READ_LATENCY(3)) u3 (
        .clock(clock), .reset_n(reset_n), .start(start), .bus(bus3.master),
        .id_value(id3), .ts_value(ts3), .busy(busy3), .done(done3), .pass(pass3),
        .fail(fail3), .mismatch(mm3), .retry_count(rc3)
    );

    // mode 0: good words, 1: bad timestamp, 2: bad ID on the first read only
    logic id_seen;
    always_ff @(posedge clock)
        if (!reset_n) id_seen <= 1'b0;
        else if (bus1.sys_read && !bus1.sys_address) id_seen <= 1'b1;

    always_comb
        bus1.sys_readdata = !bus1.sys_address ? ((mode == 2 && !id_seen) ? 32'hdeadbeef : 32'd0)
                                              : (mode == 1 ? 32'h12345678 : GOOD_TS);

    // latency-3 slave: garbage until the third cycle of a held read
    logic [1:0] seg;
    logic [7:0] n_prev, n_cur;
    always_comb n_cur = ({bus3.sys_read, bus3.sys_address} == seg) ? n_prev + 8'd1 : 8'd0;
    always_ff @(posedge clock) begin
        seg    <= {bus3.sys_read, bus3.sys_address};
        n_prev <= n_cur;
    end
    always_comb
        bus3.sys_readdata = (n_cur == 8'd2) ? (bus3.sys_address ? GOOD_TS : 32'd0) : (32'hbad00000 | 32'(n_cur));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_read", 32'(bus1.sys_read), 0);
        check("rst_rc", 32'(rc1), 0);
        check("rst_ts", ts1, 0);

        mode = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("l1_read_e%0d", e), 32'(bus1.sys_read), 32'(e <= 2));
            check($sformatf("l1_done_e%0d", e), 32'(done1), 32'(e >= 4));
            check($sformatf("l3_read_e%0d", e), 32'(bus3.sys_read), 32'(e <= 6));
            check($sformatf("l3_done_e%0d", e), 32'(done3), 32'(e >= 8));
            if (e == 2) check("l1_addr_e2", 32'(bus1.sys_address), 1);
        end
        check("l1_pass", 32'(pass1), 1);
        check("l1_fail", 32'(fail1), 0);
        check("l1_rc", 32'(rc1), 0);
        check("l1_mm", 32'(mm1), 0);
        check("l1_ts", ts1, GOOD_TS);
        check("l3_pass", 32'(pass3), 1);
        check("l3_id", id3, 0);
        check("l3_ts", ts3, GOOD_TS);
        check("l3_addr_hold", 32'(bus3.sys_address), 1);

        mode = 1;
        reset_dut();
        repeat (12) tick();
        check("bts_done_e12", 32'(done1), 0);
        tick();
        check("bts_done_e13", 32'(done1), 1);
        check("bts_fail", 32'(fail1), 1);
        check("bts_pass", 32'(pass1), 0);
        check("bts_mm", 32'(mm1), 2);
        check("bts_rc", 32'(rc1), 3);
        check("bts_ts", ts1, 32'h12345678);

        mode = 2;
        reset_dut();
        repeat (6) tick();
        check("bid_done_e6", 32'(done1), 0);
        tick();
        check("bid_pass_e7", 32'(pass1), 1);
        check("bid_rc", 32'(rc1), 1);
        check("bid_mm", 32'(mm1), 0);

        mode = 0;
        reset_dut();
        repeat (2) tick();
        check("mrst_addr_e2", 32'(bus1.sys_address), 1);
        @(negedge clock);
        reset_n = 1'b0;
        tick();
        check("mrst_busy", 32'(busy1), 0);
        check("mrst_read", 32'(bus1.sys_read), 0);
        check("mrst_addr", 32'(bus1.sys_address), 0);
        check("mrst_pass", 32'(pass1), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();
        check("mrst_done_e3", 32'(done1), 0);
        tick();
        check("mrst_pass_e4", 32'(pass1), 1);

        reset_dut();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("sb_done_e3", 32'(done1), 0);
        tick();
        check("sb_pass_e4", 32'(pass1), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sd_done", 32'(done1), 0);
        check("sd_pass", 32'(pass1), 0);
        check("sd_busy", 32'(busy1), 1);
        check("sd_ts_hold", ts1, GOOD_TS);
        repeat (2) tick();
        check("sd_done_p2", 32'(done1), 0);
        tick();
        check("sd_done_p3", 32'(done1), 1);
        check("sd_pass_p3", 32'(pass1), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
